// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of the nibble-serial adder.
// The slave side is the adder controller; the master side is whoever
// supplies operands and consumes results.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    modport slave (
        input  in_valid, op_a, op_b, op_cin, res_ready,
        output in_ready, res_valid, result, cout, zero
    );

    modport master (
        output in_valid, op_a, op_b, op_cin, res_ready,
        input  in_ready, res_valid, result, cout, zero
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder controller.
// Adds two WIDTH-bit operands one nibble per clock through an external
// combinational 4-bit parallel_adder, chaining a registered carry between
// nibbles. WIDTH must be a multiple of 4 and at least 4.
// {cout, result} = op_a + op_b + op_cin, unsigned, modulo 2^WIDTH on result.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_adder_if.slave   bus,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [NIB-1:0][3:0] a_reg;
    logic [NIB-1:0][3:0] b_reg;
    logic [NIB-1:0][3:0] result_reg;
    logic [NIB-1:0][3:0] result_next;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic                in_ready_q;
    logic                res_valid_q;
    logic                cout_q;
    logic                zero_q;

    // Adder inputs come from registered state only, and are parked at zero outside RUN.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred on any path.
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        result_next = result_reg;
        result_next[idx] = add_s;
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    // Control FSM plus datapath registers: accept, one nibble per cycle, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand registers are reset too, so add_a/add_b read zero straight out of reset.
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.op_a;
                        b_reg      <= bus.op_b;
                        carry      <= bus.op_cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry      <= add_cout;
                    idx        <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        cout_q      <= add_cout;
                        zero_q      <= (result_next == '0);
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_reg;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: a 4-bit parallel adder model is attached
// to the datapath ports, results are checked by a scoreboard monitor against
// a whole-word arithmetic reference.
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic         cout;
        logic         zero;
        logic [W-1:0] result;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_s;
    logic       add_cout;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic cin_log[$];

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Team 4-bit parallel adder, purely combinational.
    assign {add_cout, add_s} = add_a + add_b + {3'b000, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        exp_t       e;
        s        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.cout   = s[W];
        e.result = s[W-1:0];
        e.zero   = (s[W-1:0] == '0);
        return e;
    endfunction

    // Carry into nibble k: the carry out of adding the low k nibbles.
    function automatic logic nib_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input int k);
        longint mask;
        longint sum;
        mask = (longint'(1) << (4 * k)) - 1;
        sum  = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
        return (sum >> (4 * k)) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, push the expected response.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_timeout", n < 50, 1'b1);
        sb.push_back(model(a, b, cin));
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until res_valid, logging add_cin per nibble.
    task automatic wait_result(output int lat);
        lat = 0;
        cin_log.delete();
        while (!bus.res_valid && lat < 50) begin
            cin_log.push_back(add_cin);
            tick();
            lat++;
        end
    endtask

    // Scoreboard monitor: compare on every result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: result %0h with no expected entry at %0t",
                         bus.result, $time);
            end else begin
                e = sb.pop_front();
                check("result", {bus.cout, bus.zero, bus.result}, e);
            end
        end
    end

    initial begin
        vec_t dir[5];
        int   lat;
        int   na;
        int   last;
        int   cyc;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rc;

        dir[0] = '{16'h1234, 16'h4321, 1'b0};
        dir[1] = '{16'hFFFF, 16'h0001, 1'b0};
        dir[2] = '{16'h00F0, 16'h0010, 1'b1};
        dir[3] = '{16'hFFFF, 16'h0000, 1'b1};
        dir[4] = '{16'h8ACE, 16'h7531, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_result", {bus.cout, bus.zero, bus.result}, '0);
        check("rst_add", {add_a, add_b, add_cin}, '0);
        rst_n = 1'b1;
        tick();

        // Directed operands: latency and per-nibble carry chain.
        for (int i = 0; i < 5; i++) begin
            send(dir[i].a, dir[i].b, dir[i].cin);
            wait_result(lat);
            check("latency", lat, NIB);
            for (int k = 0; k < NIB && k < cin_log.size(); k++)
                check("nibble_cin", cin_log[k], nib_carry(dir[i].a, dir[i].b, dir[i].cin, k));
            tick();
            check("idle_in_ready", bus.in_ready, 1'b1);
        end

        // Backpressure: DONE holds while res_ready is low; in_valid is ignored.
        bus.res_ready = 1'b0;
        e = model(16'h8000, 16'h8000, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        wait_result(lat);
        check("bp_latency", lat, NIB);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.in_valid = 1'b1;
                bus.op_a     = 16'h1111;
                bus.op_b     = 16'h2222;
                bus.op_cin   = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            check("bp_res_valid", bus.res_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_hold", {bus.cout, bus.zero, bus.result}, e);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        check("bp_release_valid", bus.res_valid, 1'b0);
        check("bp_release_ready", bus.in_ready, 1'b1);
        check("idle_keeps_result", {bus.cout, bus.zero, bus.result}, e);

        // Asynchronous reset after two nibbles of 0xABCD + 0x1111.
        send(16'hABCD, 16'h1111, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_res_valid", bus.res_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_add", {add_a, add_b, add_cin}, '0);
        check("mid_rst_result", {bus.cout, bus.zero, bus.result}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(16'h0001, 16'h0002, 1'b0);
        wait_result(lat);
        check("post_rst_latency", lat, NIB);
        check("post_rst_sum", bus.result, 16'h0003);
        tick();

        // Random back-to-back traffic with in_valid held high.
        na   = 0;
        last = 0;
        cyc  = 0;
        ra   = W'($urandom);
        rb   = W'($urandom);
        rc   = 1'($urandom);
        bus.in_valid = 1'b1;
        bus.op_a     = ra;
        bus.op_b     = rb;
        bus.op_cin   = rc;
        while (na < 1000 && cyc < 20000) begin
            if (bus.in_ready) begin
                sb.push_back(model(ra, rb, rc));
                if (na > 0) check("accept_gap", cyc - last, NIB + 2);
                last = cyc;
                na++;
                tick();
                cyc++;
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom);
                bus.op_a   = ra;
                bus.op_b   = rb;
                bus.op_cin = rc;
                if (na == 1000) bus.in_valid = 1'b0;
            end else begin
                tick();
                cyc++;
            end
        end
        bus.in_valid = 1'b0;
        check("random_accepts", na, 1000);

        for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
        check("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
